muldiv_ctrl: RTL and testbench

Sequencer for the multicycle integer multiply/divide datapath. It accepts MULT, DIV, MTHI and MTLO requests from the main control unit and launches the multiplier or divider via their level control lines. It counts a fixed latency and captures the 64-bit result into the architectural HI/LO registers it owns. It reports busy/done/divide-by-zero so the control unit can stall MFHI/MFLO and raise the exception.

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_latency_counter.sv | 46 ++++
 rtl/muldiv_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the multiply/divide sequencer and the main control
// unit: request opcodes, sequencer state encoding and default latencies.
// ---------------------------------------------------------------------------
package muldiv_pkg;

  // Request opcodes as driven on muldiv_ctrl.Op by the control unit.
  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } op_e;

  // Sequencer states; 2'b11 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RUN_MULT = 2'b01,
    ST_RUN_DIV  = 2'b10
  } state_e;

  // Cycles from request acceptance to HI/LO capture.
  localparam int DEFAULT_MULT_LATENCY = 34;
  localparam int DEFAULT_DIV_LATENCY  = 34;
  // Counter width; must hold max(DEFAULT_MULT_LATENCY, DEFAULT_DIV_LATENCY).
  localparam int DEFAULT_CNT_W        = 6;

endpackage

// File: rtl/muldiv_latency_counter.sv
// ---------------------------------------------------------------------------
// muldiv_latency_counter
// Free-running up counter used to time a multicycle multiply/divide.
//   clk    in   system clock
//   rst    in   asynchronous active-high reset
//   clear  in   force the count back to 0 on the next edge (wins over enable)
//   enable in   increment on the next edge
//   limit  in   terminal value (latency - 1) selected by the sequencer
//   tc     out  count currently equals limit
// ---------------------------------------------------------------------------
module muldiv_latency_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == limit);

endmodule

// File: rtl/muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl
// Sequencer for the multicycle multiply/divide datapath. Accepts MULT, DIV,
// MTHI and MTLO requests in IDLE, holds the multiplier/divider launch line
// high for a fixed latency, then captures the 64-bit result into the
// architectural HI/LO registers owned here.
//   Clock                 in   system clock, rising edge
//   Reset                 in   asynchronous active-high reset
//   Start                 in   request strobe, sampled only in IDLE
//   Op[1:0]               in   00 MULT, 01 DIV, 10 MTHI, 11 MTLO
//   Operand_A/B[31:0]     in   rs / rt values
//   Mult_Control          out  level launch line to the multiplier
//   Div_Control           out  level launch line to the divider
//   Mult_HI/LO[31:0]      in   multiplier result
//   Div_HI/LO[31:0]       in   divider remainder / quotient
//   HI/LO[31:0]           out  architectural HI/LO registers
//   Busy                  out  operation in flight
//   Done                  out  one-cycle pulse, HI/LO just updated
//   Div_Zero              out  one-cycle pulse, DIV by zero rejected
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MULT_LATENCY = DEFAULT_MULT_LATENCY,
  parameter int DIV_LATENCY  = DEFAULT_DIV_LATENCY,
  parameter int CNT_W        = DEFAULT_CNT_W
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] Operand_A,
  input  logic [31:0] Operand_B,
  output logic        Mult_Control,
  output logic        Div_Control,
  input  logic [31:0] Mult_HI,
  input  logic [31:0] Mult_LO,
  input  logic [31:0] Div_HI,
  input  logic [31:0] Div_LO,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy,
  output logic        Done,
  output logic        Div_Zero
);

  // The counter reads 0 after the accepting edge, so capture happens on the
  // edge where it reads LATENCY-1: exactly LATENCY edges after acceptance.
  localparam logic [CNT_W-1:0] MULT_LIMIT = CNT_W'(MULT_LATENCY - 1);
  localparam logic [CNT_W-1:0] DIV_LIMIT  = CNT_W'(DIV_LATENCY - 1);

  op_e         op;
  state_e      state_q,     state_d;
  logic [31:0] hi_q,        hi_d;
  logic [31:0] lo_q,        lo_d;
  logic        busy_q,      busy_d;
  logic        done_q,      done_d;
  logic        div_zero_q,  div_zero_d;
  logic        mult_ctrl_q, mult_ctrl_d;
  logic        div_ctrl_q,  div_ctrl_d;

  logic             cnt_clear;
  logic             cnt_enable;
  logic [CNT_W-1:0] cnt_limit;
  logic             cnt_tc;

  assign op = op_e'(Op);

  muldiv_latency_counter #(
    .CNT_W (CNT_W)
  ) u_latency_counter (
    .clk    (Clock),
    .rst    (Reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .limit  (cnt_limit),
    .tc     (cnt_tc)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    div_zero_d  = 1'b0;
    mult_ctrl_d = 1'b0;
    div_ctrl_d  = 1'b0;
    cnt_clear   = 1'b1;
    cnt_enable  = 1'b0;
    cnt_limit   = MULT_LIMIT;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          case (op)
            OP_MULT: begin
              state_d     = ST_RUN_MULT;
              mult_ctrl_d = 1'b1;
              busy_d      = 1'b1;
            end
            OP_DIV: begin
              // A zero divisor never launches the divider.
              if (Operand_B == 32'd0) begin
                div_zero_d = 1'b1;
              end else begin
                state_d    = ST_RUN_DIV;
                div_ctrl_d = 1'b1;
                busy_d     = 1'b1;
              end
            end
            OP_MTHI: begin
              hi_d   = Operand_A;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = Operand_A;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end

      ST_RUN_MULT: begin
        cnt_limit  = MULT_LIMIT;
        cnt_enable = 1'b1;
        cnt_clear  = cnt_tc;
        if (cnt_tc) begin
          hi_d    = Mult_HI;
          lo_d    = Mult_LO;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          mult_ctrl_d = 1'b1;
          busy_d      = 1'b1;
        end
      end

      ST_RUN_DIV: begin
        cnt_limit  = DIV_LIMIT;
        cnt_enable = 1'b1;
        cnt_clear  = cnt_tc;
        if (cnt_tc) begin
          hi_d    = Div_HI;
          lo_d    = Div_LO;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          div_ctrl_d = 1'b1;
          busy_d     = 1'b1;
        end
      end

      // Unused encoding: drop both launch lines and return to IDLE.
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
      mult_ctrl_q <= 1'b0;
      div_ctrl_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      div_zero_q  <= div_zero_d;
      mult_ctrl_q <= mult_ctrl_d;
      div_ctrl_q  <= div_ctrl_d;
    end
  end

  assign HI           = hi_q;
  assign LO           = lo_q;
  assign Busy         = busy_q;
  assign Done         = done_q;
  assign Div_Zero     = div_zero_q;
  assign Mult_Control = mult_ctrl_q;
  assign Div_Control  = div_ctrl_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_muldiv_ctrl
// Directed bench for muldiv_ctrl with behavioural multiplier/divider models.
// Each model loads its operands on the first edge that sees its launch line
// high, shows a garbage pattern while iterating, and presents the true result
// 32 edges later (edge 33 after acceptance), so early capture is visible.
// ---------------------------------------------------------------------------
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] a_i = 32'd0;
  logic [31:0] b_i = 32'd0;
  logic        mult_control, div_control;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .Clock        (clk),
    .Reset        (rst),
    .Start        (start),
    .Op           (op_i),
    .Operand_A    (a_i),
    .Operand_B    (b_i),
    .Mult_Control (mult_control),
    .Div_Control  (div_control),
    .Mult_HI      (mult_hi),
    .Mult_LO      (mult_lo),
    .Div_HI       (div_hi),
    .Div_LO       (div_lo),
    .HI           (hi),
    .LO           (lo),
    .Busy         (busy),
    .Done         (done),
    .Div_Zero     (div_zero)
  );

  // Multiplier model.
  logic        m_run;
  logic [5:0]  m_cnt;
  logic [63:0] m_res;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run <= 1'b0; m_cnt <= '0; m_res <= '0;
      mult_hi <= 32'd0; mult_lo <= 32'd0;
    end else if (mult_control && !m_run) begin
      m_run   <= 1'b1;
      m_cnt   <= '0;
      m_res   <= {32'd0, a_i} * {32'd0, b_i};
      mult_hi <= 32'hBAD0_BAD0;
      mult_lo <= 32'hBAD1_BAD1;
    end else if (mult_control && m_run) begin
      m_cnt <= m_cnt + 6'd1;
      if (m_cnt == 6'd31) begin
        mult_hi <= m_res[63:32];
        mult_lo <= m_res[31:0];
      end
    end else if (!mult_control) begin
      m_run <= 1'b0;
    end
  end

  // Divider model: HI = remainder, LO = quotient.
  logic        d_run;
  logic [5:0]  d_cnt;
  logic [31:0] d_q, d_r;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      d_run <= 1'b0; d_cnt <= '0; d_q <= '0; d_r <= '0;
      div_hi <= 32'd0; div_lo <= 32'd0;
    end else if (div_control && !d_run) begin
      d_run  <= 1'b1;
      d_cnt  <= '0;
      d_q    <= (b_i == 0) ? 32'd0 : a_i / b_i;
      d_r    <= (b_i == 0) ? 32'd0 : a_i % b_i;
      div_hi <= 32'hBAD2_BAD2;
      div_lo <= 32'hBAD3_BAD3;
    end else if (div_control && d_run) begin
      d_cnt <= d_cnt + 6'd1;
      if (d_cnt == 6'd31) begin
        div_hi <= d_r;
        div_lo <= d_q;
      end
    end else if (!div_control) begin
      d_run <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive a request so edge 0 samples it; return #1 after edge 0 with Start low.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called #1 after edge 0 of a MULT/DIV. Counts Busy cycles, scrambles the
  // operands once they are no longer guaranteed, optionally pokes Start while
  // busy, and returns #1 after the edge that drops Busy.
  task automatic wait_result(input string tag, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo, input bit poke);
    int busy_cnt;
    busy_cnt = busy ? 1 : 0;
    for (int i = 1; i < 100; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        a_i = 32'hFFFF_FFFF; b_i = 32'h0000_0003;
      end
      if (poke) begin
        start = (i >= 5 && i <= 8);
        op_i  = (i == 6) ? OP_DIV : OP_MULT;
      end
      if (!busy) break;
      busy_cnt++;
    end
    start = 1'b0;
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd34);
    check({tag, "_done"},        64'(done), 64'd1);
    check({tag, "_ctrl_low"},    64'({mult_control, div_control}), 64'd0);
    check({tag, "_hi"},          64'(hi), 64'(exp_hi));
    check({tag, "_lo"},          64'(lo), 64'(exp_lo));
  endtask

  initial begin
    // Reset state.
    #12;
    check("rst_hi",   64'(hi), 64'd0);
    check("rst_lo",   64'(lo), 64'd0);
    check("rst_outs", 64'({busy, done, div_zero, mult_control, div_control}), 64'd0);
    @(negedge clk); rst = 1'b0;

    // MULT 6 * 2.
    issue(OP_MULT, 32'd6, 32'd2);
    check("mul1_e0", 64'({busy, mult_control, div_control, done}), 64'b1100);
    wait_result("mul1", 32'd0, 32'h0000_000C, 1'b0);
    @(posedge clk); #1;
    check("mul1_done_pulse", 64'({done, busy}), 64'd0);

    // MULT with Start pokes while busy (must be ignored).
    issue(OP_MULT, 32'h0010_0400, 32'h0000_0420);
    wait_result("mul2", 32'd0, 32'h4210_8000, 1'b1);
    @(posedge clk); #1;
    check("mul2_idle", 64'({done, busy, mult_control, div_control}), 64'd0);

    // DIV 100 / 7.
    issue(OP_DIV, 32'd100, 32'd7);
    check("div1_e0", 64'({busy, mult_control, div_control, done}), 64'b1010);
    wait_result("div1", 32'd2, 32'd14, 1'b0);
    @(posedge clk); #1;

    // DIV by zero: rejected in one cycle, nothing else moves.
    issue(OP_DIV, 32'd55, 32'd0);
    check("dz_pulse",  64'(div_zero), 64'd1);
    check("dz_quiet",  64'({busy, done, div_control, mult_control}), 64'd0);
    check("dz_hilo",   {hi, lo}, {32'd2, 32'd14});
    @(posedge clk); #1;
    check("dz_clear",  64'({div_zero, busy, div_control}), 64'd0);

    // MTHI then MTLO on consecutive edges.
    @(negedge clk);
    start = 1'b1; op_i = OP_MTHI; a_i = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check("mthi_hilo", {hi, lo}, {32'hDEAD_BEEF, 32'd14});
    check("mthi_flags", 64'({done, busy}), 64'b10);
    op_i = OP_MTLO; a_i = 32'h1234_5678;
    @(posedge clk); #1;
    start = 1'b0;
    check("mtlo_hilo", {hi, lo}, {32'hDEAD_BEEF, 32'h1234_5678});
    check("mtlo_flags", 64'({done, busy}), 64'b10);
    @(posedge clk); #1;
    check("mt_done_end", 64'({done, busy}), 64'd0);

    // Back-to-back MULTs: second Start arrives in the Done cycle.
    issue(OP_MULT, 32'd7, 32'd9);
    wait_result("b2b1", 32'd0, 32'd63, 1'b0);
    issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("b2b2_accept", 64'({busy, mult_control, done}), 64'b110);
    wait_result("b2b2", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    @(posedge clk); #1;

    // Asynchronous reset during cycle 15 of a MULT.
    issue(OP_MULT, 32'd1000, 32'd1000);
    repeat (15) @(posedge clk);
    #3;
    check("rst_mid_busy", 64'({busy, mult_control}), 64'b11);
    rst = 1'b1;
    #1;
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    check("rst_mid_outs", 64'({busy, done, div_zero, mult_control, div_control}), 64'd0);
    @(negedge clk); rst = 1'b0;

    issue(OP_MULT, 32'd3, 32'd5);
    wait_result("mul3", 32'd0, 32'd15, 1'b0);
    @(posedge clk); #1;
    check("mul3_idle", 64'({done, busy}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
